// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vend_pkg
// Description : Shared encodings for the coffee dispense sequencer: recipe
//               codes, sequencer states, timer width and phase ordering.
//               Optional feature macro used elsewhere: CUP_SENSE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

    localparam int TMR_W = 8;

    localparam logic [1:0] RCP_BLACK       = 2'b00;
    localparam logic [1:0] RCP_CREAM       = 2'b01;
    localparam logic [1:0] RCP_CREAM_SUGAR = 2'b10;
    localparam logic [1:0] RCP_ILLEGAL     = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WATER  = 3'd1,
        ST_COFFEE = 3'd2,
        ST_CREAM  = 3'd3,
        ST_SUGAR  = 3'd4,
        ST_GAP    = 3'd5,
        ST_DONE   = 3'd6
    } seq_state_t;

    // Valve phase that follows the given one for a latched recipe; ST_DONE
    // means the current phase was the last one.
    function automatic seq_state_t phase_after(seq_state_t cur, logic [1:0] rcp);
        seq_state_t nxt;
        nxt = ST_DONE;
        case (cur)
            ST_WATER:  nxt = ST_COFFEE;
            ST_COFFEE: nxt = (rcp != RCP_BLACK) ? ST_CREAM : ST_DONE;
            ST_CREAM:  nxt = (rcp == RCP_CREAM_SUGAR) ? ST_SUGAR : ST_DONE;
            default:   nxt = ST_DONE;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dispense_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : dispense_sequencer_if
// Description : Request/status/valve bundle between the vending controller
//               (master) and the dispense sequencer (slave). Cup_Present
//               exists only when CUP_SENSE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface dispense_sequencer_if;
    logic       Start;
    logic [1:0] Recipe;
    logic       Abort;
`ifdef CUP_SENSE_EN
    logic       Cup_Present;
`endif
    logic       Busy;
    logic       Done;
    logic       Reject;
    logic       Valve_Water;
    logic       Valve_Coffee;
    logic       Valve_Cream;
    logic       Valve_Sugar;

    modport master (
`ifdef CUP_SENSE_EN
        output Cup_Present,
`endif
        output Start, Recipe, Abort,
        input  Busy, Done, Reject,
        input  Valve_Water, Valve_Coffee, Valve_Cream, Valve_Sugar
    );

    modport slave (
`ifdef CUP_SENSE_EN
        input  Cup_Present,
`endif
        input  Start, Recipe, Abort,
        output Busy, Done, Reject,
        output Valve_Water, Valve_Coffee, Valve_Cream, Valve_Sugar
    );
endinterface
`default_nettype wire

// File: rtl/dispense_sequencer_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : Load/decrement down-counter that times one valve or gap
//               phase; Expired flags a count of zero.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_timer (
    input  logic                       Clock,
    input  logic                       nReset,
    input  logic                       Load,
    input  logic [vend_pkg::TMR_W-1:0] Value,
    output logic                       Expired
);
    import vend_pkg::*;

    logic [TMR_W-1:0] count;

    // Load on phase entry, otherwise count down and rest at zero
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            count <= '0;
        end else if (Load) begin
            count <= Value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign Expired = (count == '0);

endmodule
`default_nettype wire

// File: rtl/dispense_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dispense_sequencer
// Description : Runs the Water/Coffee/Cream/Sugar valves one at a time for
//               programmed cycle counts with an optional idle gap between
//               phases. Reports Busy/Done/Reject and honours Abort.
//               Optional feature: CUP_SENSE_EN (cup presence interlock).
// Revision    : 1.0 - initial release
// ============================================================================
module dispense_sequencer #(
    parameter int WATER_CYC  = 4,
    parameter int COFFEE_CYC = 3,
    parameter int CREAM_CYC  = 2,
    parameter int SUGAR_CYC  = 2,
    parameter int GAP_CYC    = 1
) (
    input  logic                 Clock,
    input  logic                 nReset,
    dispense_sequencer_if.slave  bus
);
    import vend_pkg::*;

    seq_state_t       state, state_nxt;
    seq_state_t       resume, resume_nxt;
    seq_state_t       follow;
    logic [1:0]       recipe, recipe_nxt;
    logic             reject, reject_nxt;
    logic             load;
    logic [TMR_W-1:0] load_val;
    logic             expired;
    logic             stop;
    logic             cup_ok;

`ifdef CUP_SENSE_EN
    // A cup lifted mid-drink stops the sequence exactly like Abort
    assign cup_ok = bus.Cup_Present;
    assign stop   = bus.Abort | ~bus.Cup_Present;
`else
    assign cup_ok = 1'b1;
    assign stop   = bus.Abort;
`endif

    // Timer reload value for a phase: N-1 so the phase lasts exactly N cycles
    function automatic logic [TMR_W-1:0] phase_load(seq_state_t s);
        logic [TMR_W-1:0] v;
        v = '0;
        case (s)
            ST_WATER:  v = TMR_W'(WATER_CYC - 1);
            ST_COFFEE: v = TMR_W'(COFFEE_CYC - 1);
            ST_CREAM:  v = TMR_W'(CREAM_CYC - 1);
            ST_SUGAR:  v = TMR_W'(SUGAR_CYC - 1);
            ST_GAP:    v = TMR_W'(GAP_CYC - 1);
            default:   v = '0;
        endcase
        return v;
    endfunction

    assign follow = phase_after(state, recipe);

    phase_timer u_timer (
        .Clock   (Clock),
        .nReset  (nReset),
        .Load    (load),
        .Value   (load_val),
        .Expired (expired)
    );

    // Next-state, timer reload and reject decision
    always_comb begin
        state_nxt  = state;
        resume_nxt = resume;
        recipe_nxt = recipe;
        reject_nxt = 1'b0;
        load       = 1'b0;
        load_val   = '0;
        case (state)
            ST_IDLE: begin
                // Abort alongside Start suppresses both acceptance and Reject
                if (bus.Start && !bus.Abort) begin
                    if ((bus.Recipe == RCP_ILLEGAL) || !cup_ok) begin
                        reject_nxt = 1'b1;
                    end else begin
                        state_nxt  = ST_WATER;
                        recipe_nxt = bus.Recipe;
                        load       = 1'b1;
                        load_val   = phase_load(ST_WATER);
                    end
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (expired) begin
                    state_nxt = resume;
                    load      = 1'b1;
                    load_val  = phase_load(resume);
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (expired) begin
                    if (follow == ST_DONE) begin
                        state_nxt = ST_DONE;
                    end else if (GAP_CYC > 0) begin
                        state_nxt  = ST_GAP;
                        resume_nxt = follow;
                        load       = 1'b1;
                        load_val   = phase_load(ST_GAP);
                    end else begin
                        state_nxt = follow;
                        load      = 1'b1;
                        load_val  = phase_load(follow);
                    end
                end
            end
        endcase
    end

    // State, pending phase, latched recipe and Reject pulse registers
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state  <= ST_IDLE;
            resume <= ST_IDLE;
            recipe <= RCP_BLACK;
            reject <= 1'b0;
        end else begin
            state  <= state_nxt;
            resume <= resume_nxt;
            recipe <= recipe_nxt;
            reject <= reject_nxt;
        end
    end

    assign bus.Busy         = (state != ST_IDLE);
    assign bus.Done         = (state == ST_DONE);
    assign bus.Reject       = reject;
    assign bus.Valve_Water  = (state == ST_WATER);
    assign bus.Valve_Coffee = (state == ST_COFFEE);
    assign bus.Valve_Cream  = (state == ST_CREAM);
    assign bus.Valve_Sugar  = (state == ST_SUGAR);

endmodule
`default_nettype wire

// File: tb/tb_dispense_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispense_sequencer
// Description : Scoreboard bench for dispense_sequencer. dut0 uses default
//               timing (GAP_CYC=1), dut1 uses GAP_CYC=0. Extra cup-sense
//               checks build when CUP_SENSE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispense_sequencer;

    localparam logic [6:0] B_BUSY = 7'b1000000;
    localparam logic [6:0] B_DONE = 7'b0100000;
    localparam logic [6:0] B_REJ  = 7'b0010000;
    localparam logic [6:0] B_W    = 7'b0001000;

    typedef struct {
        int         cyc;
        logic [6:0] v;
    } exp_t;

    logic Clock  = 1'b0;
    logic nReset = 1'b0;
    int   edge_n = 0;
    int   total  = 0;
    int   bad    = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 Clock = ~Clock;

    // Edge counter: a sample taken just after edge e carries stamp e
    always @(posedge Clock) edge_n <= edge_n + 1;

    dispense_sequencer_if if0 ();
    dispense_sequencer_if if1 ();

    dispense_sequencer #(.GAP_CYC(1)) dut0 (.Clock(Clock), .nReset(nReset), .bus(if0));
    dispense_sequencer #(.GAP_CYC(0)) dut1 (.Clock(Clock), .nReset(nReset), .bus(if1));

    logic [6:0] v0, v1;
    assign v0 = {if0.Busy, if0.Done, if0.Reject, if0.Valve_Water,
                 if0.Valve_Coffee, if0.Valve_Cream, if0.Valve_Sugar};
    assign v1 = {if1.Busy, if1.Done, if1.Reject, if1.Valve_Water,
                 if1.Valve_Coffee, if1.Valve_Cream, if1.Valve_Sugar};

    task automatic push(input int id, input int cyc, input logic [6:0] v);
        exp_t e;
        e.cyc = cyc;
        e.v   = v;
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    // Expected timeline of one accepted drink started at edge s.
    // Spec cycle j is observed after edge s+j-1; cycles >= cut are dropped.
    task automatic expect_run(input int id, input int s, input logic [1:0] rcp,
                              input int cut);
        int lens[4];
        int gap;
        int nph;
        int j;
        lens = '{4, 3, 2, 2};
        gap  = (id == 0) ? 1 : 0;
        nph  = (rcp == 2'b00) ? 2 : (rcp == 2'b01) ? 3 : 4;
        j    = 1;
        for (int p = 0; p < nph; p++) begin
            if (p > 0) begin
                for (int g = 0; g < gap; g++) begin
                    if (cut == 0 || j < cut) push(id, s + j - 1, B_BUSY);
                    j++;
                end
            end
            for (int c = 0; c < lens[p]; c++) begin
                if (cut == 0 || j < cut) push(id, s + j - 1, B_BUSY | (B_W >> p));
                j++;
            end
        end
        if (cut == 0 || j < cut) push(id, s + j - 1, B_BUSY | B_DONE);
    endtask

    // Called at a negedge: raise Start, queue the expected response, drop
    // Start at the next negedge and scramble Recipe to prove it was latched.
    task automatic issue(input int id, input logic [1:0] rcp, input bit rej,
                         input int cut, output int s);
        if (id == 0) begin if0.Start = 1'b1; if0.Recipe = rcp; end
        else         begin if1.Start = 1'b1; if1.Recipe = rcp; end
        s = edge_n + 1;
        if (rej || rcp == 2'b11) push(id, s, B_REJ);
        else                     expect_run(id, s, rcp, cut);
        @(negedge Clock);
        if (id == 0) begin if0.Start = 1'b0; if0.Recipe = ~rcp; end
        else         begin if1.Start = 1'b0; if1.Recipe = ~rcp; end
    endtask

    task automatic wait_edge(input int e);
        while (edge_n < e) @(negedge Clock);
    endtask

    task automatic drain(input int id);
        int n;
        n = 0;
        while (((id == 0) ? q0.size() : q1.size()) > 0 && n < 200) begin
            @(negedge Clock);
            n++;
        end
        if (((id == 0) ? q0.size() : q1.size()) > 0) begin
            total++;
            bad++;
            $display("FAIL drain dut%0d: %0d expected responses never appeared, required 0",
                     id, (id == 0) ? q0.size() : q1.size());
        end
    endtask

    task automatic mon(input int id, input logic [6:0] v);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (v != 7'b0) begin
            total++;
            if (id == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (id == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            if (!have) begin
                bad++;
                $display("FAIL unexpected dut%0d @edge %0d: got %b, required no activity",
                         id, edge_n, v);
            end else if (e.cyc != edge_n || e.v != v) begin
                bad++;
                $display("FAIL output dut%0d: got %b @edge %0d, required %b @edge %0d",
                         id, v, edge_n, e.v, e.cyc);
            end
        end
    endtask

    // Monitor: samples both DUTs 1 time unit after each rising edge
    always @(posedge Clock) begin
        #1;
        mon(0, v0);
        mon(1, v1);
    end

    task automatic chk_zero(input string name, input logic [6:0] v);
        total++;
        if (v != 7'b0) begin
            bad++;
            $display("FAIL %s: got %b, required 0000000", name, v);
        end
    endtask

    initial begin
        int s;
        int s2;
        if0.Start = 1'b0; if0.Recipe = 2'b00; if0.Abort = 1'b0;
        if1.Start = 1'b0; if1.Recipe = 2'b00; if1.Abort = 1'b0;
`ifdef CUP_SENSE_EN
        if0.Cup_Present = 1'b1;
        if1.Cup_Present = 1'b1;
`endif
        repeat (2) @(negedge Clock);
        chk_zero("reset_dut0", v0);
        chk_zero("reset_dut1", v1);
        nReset = 1'b1;
        @(negedge Clock);

        // Black, default timing; a Start with Recipe=11 while Busy is ignored
        issue(0, 2'b00, 1'b0, 0, s);
        wait_edge(s + 2);
        if0.Start = 1'b1; if0.Recipe = 2'b11;
        @(negedge Clock);
        if0.Start = 1'b0;
        drain(0);

        // Cream+sugar, back-to-back phases
        @(negedge Clock);
        issue(1, 2'b10, 1'b0, 0, s);
        drain(1);

        // Illegal recipe rejected, then a cream Start the very next cycle
        @(negedge Clock);
        issue(0, 2'b11, 1'b0, 0, s);
        issue(0, 2'b01, 1'b0, 0, s);
        drain(0);

        // Abort in cycle 7 of a cream run, new Start in cycle 8
        @(negedge Clock);
        issue(0, 2'b01, 1'b0, 8, s);
        wait_edge(s + 6);
        if0.Abort = 1'b1;
        @(negedge Clock);
        if0.Abort = 1'b0;
        issue(0, 2'b00, 1'b0, 0, s2);
        drain(0);

        // Abort together with Start in IDLE: nothing happens
        @(negedge Clock);
        if0.Start = 1'b1; if0.Recipe = 2'b00; if0.Abort = 1'b1;
        @(negedge Clock);
        if0.Start = 1'b0; if0.Abort = 1'b0;
        repeat (4) @(negedge Clock);

        // Asynchronous reset in the middle of CREAM, then a fresh drink
        issue(1, 2'b01, 1'b0, 0, s);
        wait_edge(s + 7);
        #2 nReset = 1'b0;
        #1 chk_zero("async_reset_dut1", v1);
        q1.delete();
        @(negedge Clock);
        @(negedge Clock);
        nReset = 1'b1;
        @(negedge Clock);
        issue(1, 2'b00, 1'b0, 0, s);
        drain(1);

`ifdef CUP_SENSE_EN
        // No cup at Start is rejected; cup lifted during Coffee stops the run
        @(negedge Clock);
        if0.Cup_Present = 1'b0;
        issue(0, 2'b00, 1'b1, 0, s);
        if0.Cup_Present = 1'b1;
        @(negedge Clock);
        issue(0, 2'b00, 1'b0, 7, s);
        wait_edge(s + 5);
        if0.Cup_Present = 1'b0;
        @(negedge Clock);
        if0.Cup_Present = 1'b1;
        drain(0);
`endif

        repeat (4) @(negedge Clock);
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d/%0d queued, required 0/0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dispense_sequencer.md
# dispense_sequencer

Timed valve sequencer between the coffee vending controller and the dispenser hardware. It accepts one recipe request per drink and drives the Water, Coffee, Cream and Sugar valves strictly one at a time, because they share a single pump. Each valve runs for a programmed number of cycles, with an optional idle gap between valves. It reports Busy and Done, and supports Abort.

## Interface
- WATER_CYC, default 4: cycles Valve_Water is open; legal range 1..255.
- COFFEE_CYC, default 3: cycles Valve_Coffee is open; legal range 1..255.
- CREAM_CYC, default 2: cycles Valve_Cream is open; legal range 1..255.
- SUGAR_CYC, default 2: cycles Valve_Sugar is open; legal range 1..255.
- GAP_CYC, default 1: all-valves-off cycles between consecutive valve phases; legal range 0..255 (0 means no gap).
- Clock  input  1  system clock; all logic is on its rising edge.
- nReset  input  1  reset; asynchronous, active-low. Reset nReset, asynchronous, active-low; clock Clock.
- Start  input  1  request pulse; sampled only in IDLE.
- Recipe  input  2  00 = black, 01 = cream, 10 = cream+sugar, 11 = illegal; sampled with Start.
- Abort  input  1  stops the sequence; all valves close.
- Busy  output  1  high from the first valve cycle through the DONE cycle.
- Done  output  1  one-cycle pulse at normal completion.
- Reject  output  1  one-cycle pulse when Start is refused.
- Valve_Water, Valve_Coffee, Valve_Cream, Valve_Sugar  output  1 each  valve drives; at most one is high in any cycle.

## Operation
- States: IDLE, WATER, COFFEE, CREAM, SUGAR, GAP, DONE.
  - The current state is held in a register.
  - Valve, Busy and Done outputs are decoded from registered state only; there is no input-to-output path.
  - Reject is a registered pulse.
- Phase order:
  - WATER, then COFFEE.
  - If Recipe ≥ 01, then CREAM.
  - If Recipe = 10, then SUGAR.
  - After the last phase, DONE for 1 cycle, then IDLE.
  - The recipe is latched on acceptance; later Recipe changes are ignored.
- Start handling in IDLE:
  - Start=1 with a legal Recipe and Abort=0: enter WATER.
  - Start=1 with Recipe=11: Reject=1 next cycle; stay in IDLE.
- GAP:
  - Entered between valve phases only when GAP_CYC>0.
  - Never entered before WATER or after the last phase.
- Phase timer:
  - Loaded with N−1 on phase entry and decremented each cycle.
  - At 0, advance to the next state. Each phase therefore lasts exactly N cycles.
  - Width is 8 bits.
- Start while Busy: ignored, with no Reject and no queuing.
- Abort in any state other than IDLE:
  - Next state is IDLE, so all valves and Busy are low on the following cycle.
  - Done is not asserted.
- Abort together with Start in IDLE: Abort wins; the request is not accepted and Reject is not asserted.
- Reset, including mid-sequence: state = IDLE, timer = 0, latched recipe = 00, all outputs 0.

## Timing
- Start sampled at edge 0 (accepted) → Busy and Valve_Water are high from cycle 1.
- Black recipe, defaults:
  - Water cycles 1–4.
  - Gap cycle 5.
  - Coffee cycles 6–8.
  - DONE in cycle 9, with Done=1 and Busy=1.
  - IDLE in cycle 10.
- Total Busy cycles = sum of the selected phase lengths + GAP_CYC × (phases − 1) + 1.
- A new Start is accepted in the first IDLE cycle after DONE (cycle 10 above).
- Abort sampled in cycle k → valves low from cycle k+1.

## Configuration
- CUP_SENSE_EN defined:
  - Adds input Cup_Present (1 bit).
  - Start in IDLE with Cup_Present=0 is rejected (Reject pulse).
  - Cup_Present falling while Busy behaves exactly like Abort.
- CUP_SENSE_EN undefined: the port is absent and cup presence is not checked.

## Structure
- The shared package vend_pkg holds:
  - Recipe encodings RCP_BLACK, RCP_CREAM, RCP_CREAM_SUGAR, RCP_ILLEGAL.
  - Sequencer state encodings.
  - Timer width TMR_W = 8.
- One sub-module: phase_timer.
  - 8-bit load/decrement counter.
  - Inputs Load, Value; output Expired (count == 0).
  - Instantiated once.

## Test plan
- Black recipe, defaults: Start with Recipe=00 → Valve_Water in cycles 1–4, Valve_Coffee in 6–8, Done in cycle 9, no Cream or Sugar.
- Cream+sugar with GAP_CYC=0: Start with Recipe=10 → valves W(4) C(3) Cr(2) S(2) back-to-back, Done in cycle 12, never two valves high together.
- Illegal recipe: Start with Recipe=11 → Reject in cycle 1, Busy stays 0; a Start with Recipe=01 in the next cycle is accepted normally.
- Abort in cycle 7 of a cream run → all valves 0 from cycle 8, no Done; a new Start in cycle 8 is accepted.
- nReset asserted mid-CREAM → all outputs 0 immediately (asynchronous); after release, IDLE and a fresh Start works.
- With CUP_SENSE_EN defined: Cup_Present=0 at Start → Reject; Cup_Present dropped during Coffee → valves off next cycle, no Done.
